mult_compare_display: RTL
=========================

Name: mult_compare_display

Overview:
Parametrised multiply/compare/display unit, the next generation of the lab's fixed 8x8 comparator top.
- Two operands are loaded from a shared input bus.
- A sequential shift-add multiplier runs under a start/busy/done handshake.
- The product can be captured as a reference; product vs reference gives LT/EQ/GT.
- The product is shown as hex on a time-multiplexed N-digit 7-segment display.

Parameters:
WIDTH, 8, operand width in bits; product width is 2*WIDTH.
DIGITS, 4, number of display digits; must satisfy 4*DIGITS >= 2*WIDTH (elaboration error otherwise).
SCAN_DIV, 199999, clk cycles per digit-scan step minus one (digit advances every SCAN_DIV+1 cycles).

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous, active-high reset
bin  input  WIDTH  shared operand / data input
load  input  3  [0] load A, [1] load B, [2] capture product into reference
start  input  1  one-cycle pulse; begin multiply of A*B
busy  output  1  high while the multiplier is running
done  output  1  one-cycle pulse when the product register is updated
product  output  2*WIDTH  last completed product
cat  output  8  segment cathodes, active-low; [0]=a .. [6]=g, [7]=dp
segan  output  DIGITS  digit anodes, active-low one-hot
compare  output  3  [0] LT, [1] EQ, [2] GT (product vs reference)

Behaviour:
- Reset values:
  - A, B, product, reference = 0; state = IDLE; busy = 0; done = 0.
  - compare = 3'b010 (0 == 0).
  - Scan counter = 0; digit index = 0.
  - cat = 8'hFF; segan = all ones.
  - These hold on the first cycle after rst deasserts.
- Operand loads:
  - load[0]/load[1] register bin into A/B on the clock edge.
  - Ignored while busy = 1.
  - load[0] and load[1] together load both.
- Reference capture:
  - load[2] copies the product register (not a partial result) into reference.
  - Allowed in any state.
  - If load[2] and done occur in the same cycle, the reference takes the OLD product.
- FSM: IDLE -> RUN -> DONE -> IDLE.
  - IDLE: start=1 latches A into a multiplicand shifter and B into a multiplier shifter, clears the accumulator, sets bit counter = WIDTH, goes to RUN, busy=1 next cycle.
  - RUN: each cycle, if multiplier LSB=1, accumulator += shifted multiplicand. Multiplicand shifts left, multiplier shifts right, counter decrements. After exactly WIDTH RUN cycles, go to DONE.
  - DONE: product <= accumulator, done=1 for this one cycle, busy=0, return to IDLE.
  - Latency: start at cycle t gives done at t+WIDTH+1.
  - start while busy or in DONE is ignored, not queued.
- Arithmetic: unsigned; product width 2*WIDTH; no overflow possible.
- Compare:
  - Registered, one cycle after product or reference changes.
  - Exactly one bit set at all times.
- Display scan:
  - Free-running counter 0..SCAN_DIV; on wrap, digit index increments modulo DIGITS.
  - Digit d shows product nibble [4d+3:4d]; nibbles above 2*WIDTH read as 0.
  - segan[d] = 0 only for the active digit.
  - cat is a registered hex decode, dp always off. Codes: 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8, 8=80, 9=90, A=88, b=83, C=C6, d=A1, E=86, F=8E.
  - segan and cat change on the same edge (no ghosting).
- rst mid-multiply: aborts the operation; outputs return to reset values; no done pulse.

Optional Feature:
LEADING_ZERO_BLANK_EN:
- Defined: a digit d > 0 is blanked (cat = 8'hFF, anode still driven) when it and every higher digit are zero nibbles. Digit 0 always displays, so a zero product shows a single "0".
- Undefined: all DIGITS digits always show, including leading zeros.

Test Plan:
- Reset check: rst for 2 cycles -> product=0, compare=3'b010, busy=0, cat=8'hFF, segan=4'hF.
- Multiply: load A=8'd13, B=8'd11, pulse start -> busy for 8 cycles, done 9 cycles after start, product=16'd143 (0x008F), compare=3'b100 (GT vs ref 0).
- Edge values and ignored load:
  - A=B=8'hFF -> product=16'hFE01.
  - load[0] with bin=0 during busy -> A unchanged; next multiply still gives 16'hFE01.
- Reference capture:
  - Capture 0x008F; compare -> 3'b010.
  - Then multiply 2*3 -> product=6, compare=3'b001.
  - load[2] on the done cycle -> reference keeps the previous product.
- Display, SCAN_DIV=3, product 0x008F: anodes cycle 1110, 1101, 1011, 0111 every 4 clk; cat = 8E, 80, C0, C0. With LEADING_ZERO_BLANK_EN, cat for digits 2 and 3 = FF.
- Reset mid-operation: rst asserted 3 cycles into RUN -> no done pulse, busy=0, product=0; then start with WIDTH=16, DIGITS=4, A=B=16'hFFFF -> product=32'hFFFE0001.

Source files
------------

// File: rtl/mult_compare_display.sv
// Multiply/compare/display unit: shift-add multiplier with start/busy/done, product vs reference
// compare, and a multiplexed hex 7-segment display. Optional macro LEADING_ZERO_BLANK_EN blanks leading zero digits.
module mult_compare_display #(
  parameter int WIDTH    = 8,
  parameter int DIGITS   = 4,
  parameter int SCAN_DIV = 199999
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WIDTH-1:0]     bin,
  input  logic [2:0]           load,
  input  logic                 start,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product,
  output logic [7:0]           cat,
  output logic [DIGITS-1:0]    segan,
  output logic [2:0]           compare
);

  localparam int PW = 2 * WIDTH;
  localparam int CW = $clog2(WIDTH + 1);
  localparam int SW = (SCAN_DIV > 0) ? $clog2(SCAN_DIV + 1) : 1;
  localparam int DW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  if (4 * DIGITS < 2 * WIDTH) begin : g_bad_digits
    $error("mult_compare_display: DIGITS too small to show the full product");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t              state_r, state_s;
  logic                busy_s, done_s;
  logic                busy_r, done_r;
  logic [WIDTH-1:0]    a_r, b_r;
  logic [PW-1:0]       mcand_r, acc_r;
  logic [WIDTH-1:0]    mplier_r;
  logic [CW-1:0]       cnt_r;
  logic [PW-1:0]       product_r, ref_r;
  logic [2:0]          compare_r;
  logic [SW-1:0]       scan_r;
  logic [DW-1:0]       digit_r;
  logic [DIGITS-1:0]   segan_r, anode_s;
  logic [7:0]          cat_r;
  logic [4*DIGITS-1:0] disp_s;
  logic [3:0]          nib_s;
  logic                blank_s;

  function automatic logic [7:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: hex7 = 8'hC0;
      4'h1: hex7 = 8'hF9;
      4'h2: hex7 = 8'hA4;
      4'h3: hex7 = 8'hB0;
      4'h4: hex7 = 8'h99;
      4'h5: hex7 = 8'h92;
      4'h6: hex7 = 8'h82;
      4'h7: hex7 = 8'hF8;
      4'h8: hex7 = 8'h80;
      4'h9: hex7 = 8'h90;
      4'hA: hex7 = 8'h88;
      4'hB: hex7 = 8'h83;
      4'hC: hex7 = 8'hC6;
      4'hD: hex7 = 8'hA1;
      4'hE: hex7 = 8'h86;
      4'hF: hex7 = 8'h8E;
      default: hex7 = 8'hFF;
    endcase
  endfunction

  // State register; busy/done are registered from the next state
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      busy_r  <= busy_s;
      done_r  <= done_s;
    end
  end

  // Next-state logic; start is only honoured in IDLE
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) state_s = RUN;
        else       state_s = IDLE;
      end
      RUN: begin
        if (cnt_r == CW'(1)) state_s = DONE;
        else                 state_s = RUN;
      end
      DONE:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // Output decode of the upcoming state
  always_comb begin
    busy_s = 1'b0;
    done_s = 1'b0;
    case (state_s)
      RUN:     busy_s = 1'b1;
      DONE:    done_s = 1'b1;
      IDLE:    busy_s = 1'b0;
      default: busy_s = 1'b0;
    endcase
  end

  // Operand/reference registers and the shift-add datapath.
  // The reference samples product_r before the DONE update lands, so a same-cycle capture gets the old product.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_r       <= '0;
      b_r       <= '0;
      mcand_r   <= '0;
      mplier_r  <= '0;
      acc_r     <= '0;
      cnt_r     <= '0;
      product_r <= '0;
      ref_r     <= '0;
    end else begin
      if (!busy_r) begin
        if (load[0]) a_r <= bin;
        if (load[1]) b_r <= bin;
      end
      if (load[2]) ref_r <= product_r;
      case (state_r)
        IDLE: begin
          if (start) begin
            mcand_r  <= PW'(a_r);
            mplier_r <= b_r;
            acc_r    <= '0;
            cnt_r    <= CW'(WIDTH);
          end
        end
        RUN: begin
          if (mplier_r[0]) acc_r <= acc_r + mcand_r;
          mcand_r  <= mcand_r << 1;
          mplier_r <= mplier_r >> 1;
          cnt_r    <= cnt_r - CW'(1);
        end
        DONE:    product_r <= acc_r;
        default: ;
      endcase
    end
  end

  // Registered magnitude compare, one-hot LT/EQ/GT
  always_ff @(posedge clk) begin
    if (rst) compare_r <= 3'b010;
    else     compare_r <= {product_r > ref_r, product_r == ref_r, product_r < ref_r};
  end

  // Free-running scan prescaler and digit index
  always_ff @(posedge clk) begin
    if (rst) begin
      scan_r  <= '0;
      digit_r <= '0;
    end else if (scan_r == SW'(SCAN_DIV)) begin
      scan_r  <= '0;
      digit_r <= (digit_r == DW'(DIGITS - 1)) ? '0 : digit_r + DW'(1);
    end else begin
      scan_r  <= scan_r + SW'(1);
    end
  end

  // Product zero-extended to the full display width
  always_comb begin
    disp_s = '0;
    disp_s[PW-1:0] = product_r;
  end

  // Active-digit nibble select and one-cold anode pattern
  always_comb begin
    nib_s   = 4'h0;
    anode_s = '1;
    for (int d = 0; d < DIGITS; d++) begin
      if (digit_r == DW'(d)) begin
        nib_s      = disp_s[4*d +: 4];
        anode_s[d] = 1'b0;
      end else begin
        anode_s[d] = 1'b1;
      end
    end
  end

`ifdef LEADING_ZERO_BLANK_EN
  logic [DIGITS-1:0] upper_zero_s;
  logic              lz_run_s;

  // upper_zero_s[d]: nibble d and every nibble above it are zero; digit 0 is never blanked
  always_comb begin
    lz_run_s     = 1'b1;
    upper_zero_s = '0;
    blank_s      = 1'b0;
    for (int d = DIGITS - 1; d >= 0; d--) begin
      lz_run_s        = lz_run_s & (disp_s[4*d +: 4] == 4'h0);
      upper_zero_s[d] = lz_run_s;
    end
    for (int d = 1; d < DIGITS; d++) begin
      blank_s = blank_s | ((digit_r == DW'(d)) & upper_zero_s[d]);
    end
  end
`else
  assign blank_s = 1'b0;
`endif

  // Anodes and cathodes update on the same edge to avoid ghosting
  always_ff @(posedge clk) begin
    if (rst) begin
      segan_r <= '1;
      cat_r   <= 8'hFF;
    end else begin
      segan_r <= anode_s;
      cat_r   <= blank_s ? 8'hFF : hex7(nib_s);
    end
  end

  assign busy    = busy_r;
  assign done    = done_r;
  assign product = product_r;
  assign compare = compare_r;
  assign segan   = segan_r;
  assign cat     = cat_r;

endmodule
